dac_tx: RTL and testbench

Serial DAC transmitter at the output end of the equalizer chain. It accepts one summed band sample `y` per `tx` strobe from the filter bank. Each accepted sample is converted from signed fixed point to a 12-bit offset-binary code, with saturation, and shifted out as a 16-bit SPI-style frame to an external DAC121S101-class converter. It mirrors the sample receiver on the input side: the receiver raises `rx` when a sample arrives, and this block consumes the `tx` strobe when a sample leaves.

---
 rtl/dac_tx_pkg.sv | 14 +
 rtl/dac_tx_if.sv | 18 +
 rtl/dac_conv.sv | 35 +++
 rtl/dac_tx.sv | 107 ++++++++++
 tb/tb_dac_tx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_tx_pkg.sv
// Shared constants, state encoding and frame packing for the serial DAC transmitter.
package dac_tx_pkg;

    localparam int frame_len = 16;
    localparam int code_w    = 12;
    localparam logic [1:0] pd_normal = 2'b00;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    function automatic logic [frame_len-1:0] make_frame(input logic [code_w-1:0] code);
        return {2'b00, pd_normal, code};
    endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Sample-in / serial-out signal bundle of the DAC transmitter.
interface dac_tx_if #(
    parameter int cant_bits = 25
) ();

    logic                        tx;
    logic signed [cant_bits-1:0] y;
    logic                        sclk;
    logic                        sync_n;
    logic                        sdata;
    logic                        busy;
    logic                        done;
    logic                        ovr;

    modport master (output tx, y, input sclk, sync_n, sdata, busy, done, ovr);
    modport slave  (input tx, y, output sclk, sync_n, sdata, busy, done, ovr);

endinterface

// File: rtl/dac_conv.sv
// Signed fixed-point sample to 12-bit offset-binary DAC code, with saturation.
module dac_conv
    import dac_tx_pkg::*;
#(
    parameter int cant_bits = 25,
    parameter int frac_bits = 15
) (
    input  logic signed [cant_bits-1:0] y,
    output logic        [code_w-1:0]    code
);

    localparam int sh = frac_bits - 11;
    localparam logic signed [cant_bits-1:0] s_max = cant_bits'(2047);
    localparam logic signed [cant_bits-1:0] s_min = cant_bits'(-2048);

    function automatic logic signed [code_w-1:0] sat(input logic signed [cant_bits-1:0] s);
        if (s > s_max)
            return s_max[code_w-1:0];
        else if (s < s_min)
            return s_min[code_w-1:0];
        else
            return s[code_w-1:0];
    endfunction

    logic signed [cant_bits-1:0] s;
    logic signed [code_w-1:0]    c;

    always_comb begin
        s    = y >>> sh;
        c    = sat(s);
        // offset binary: flipping the sign bit adds 2048
        code = {~c[code_w-1], c[code_w-2:0]};
    end

endmodule

// File: rtl/dac_tx.sv
// Serial DAC transmitter: captures one sample per tx strobe and shifts out a 16-bit frame.
module dac_tx
    import dac_tx_pkg::*;
#(
    parameter int cant_bits = 25,
    parameter int frac_bits = 15,
    parameter int half      = 2
) (
    input  logic     clk,
    input  logic     rst,
    dac_tx_if.slave  bus
);

    localparam int hw = (half > 1) ? $clog2(half) : 1;
    localparam logic [hw-1:0] h_last = hw'(half - 1);

    state_t                      state, state_next;
    logic   [hw-1:0]             hcnt;
    logic   [3:0]                bcnt;
    logic   [frame_len-1:0]      shreg;
    logic signed [cant_bits-1:0] y_r;
    logic   [code_w-1:0]         code;
    logic                        sclk_r, sync_n_r, busy_r, done_r, ovr_r;
    logic                        h_end, bit_end;

    assign h_end   = (hcnt == h_last);
    assign bit_end = h_end && !sclk_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.tx) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (bit_end && bcnt == 4'd15) state_next = GAP;
            GAP:     if (h_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // sample register: only written on an accepted strobe, so overruns leave it intact
    always_ff @(posedge clk) begin
        if (bus.tx && state == IDLE)
            y_r <= bus.y;
    end

    dac_conv #(.cant_bits(cant_bits), .frac_bits(frac_bits)) u_conv (
        .y    (y_r),
        .code (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt     <= '0;
            bcnt     <= '0;
            shreg    <= '0;
            sclk_r   <= 1'b1;
            sync_n_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            busy_r   <= (state_next != IDLE);
            sync_n_r <= (state_next != SHIFT);
            done_r   <= (state == GAP) && (state_next == IDLE);
            if (bus.tx && state != IDLE)
                ovr_r <= 1'b1;
            case (state)
                LOAD: begin
                    shreg  <= make_frame(code);
                    hcnt   <= '0;
                    bcnt   <= '0;
                    sclk_r <= 1'b1;
                end
                SHIFT: begin
                    if (h_end) begin
                        hcnt   <= '0;
                        sclk_r <= !sclk_r;
                        // next bit appears with the rising sclk; the last shift leaves zeros
                        if (!sclk_r) begin
                            shreg <= {shreg[frame_len-2:0], 1'b0};
                            bcnt  <= bcnt + 4'd1;
                        end
                    end else begin
                        hcnt <= hcnt + hw'(1);
                    end
                end
                GAP:     hcnt <= h_end ? '0 : hcnt + hw'(1);
                default: hcnt <= '0;
            endcase
        end
    end

    assign bus.sclk   = sclk_r;
    assign bus.sync_n = sync_n_r;
    assign bus.sdata  = shreg[frame_len-1];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.ovr    = ovr_r;

endmodule

// File: tb/tb_dac_tx.sv
// Directed bench for dac_tx at half = 2, 1 and 5 with an sclk-edge frame monitor.
module tb_dac_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_tx_if #(.cant_bits(25)) bus2 ();
    dac_tx_if #(.cant_bits(25)) bus1 ();
    dac_tx_if #(.cant_bits(25)) bus5 ();

    dac_tx #(.cant_bits(25), .frac_bits(15), .half(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    dac_tx #(.cant_bits(25), .frac_bits(15), .half(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dac_tx #(.cant_bits(25), .frac_bits(15), .half(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    logic        tx_d [3];
    logic [24:0] y_d  [3];
    logic        sclk_o [3], sync_n_o [3], sdata_o [3], busy_o [3], done_o [3], ovr_o [3];

    assign bus2.tx = tx_d[0];  assign bus2.y = y_d[0];
    assign bus1.tx = tx_d[1];  assign bus1.y = y_d[1];
    assign bus5.tx = tx_d[2];  assign bus5.y = y_d[2];

    assign sclk_o[0] = bus2.sclk;  assign sync_n_o[0] = bus2.sync_n;  assign sdata_o[0] = bus2.sdata;
    assign busy_o[0] = bus2.busy;  assign done_o[0]   = bus2.done;    assign ovr_o[0]   = bus2.ovr;
    assign sclk_o[1] = bus1.sclk;  assign sync_n_o[1] = bus1.sync_n;  assign sdata_o[1] = bus1.sdata;
    assign busy_o[1] = bus1.busy;  assign done_o[1]   = bus1.done;    assign ovr_o[1]   = bus1.ovr;
    assign sclk_o[2] = bus5.sclk;  assign sync_n_o[2] = bus5.sync_n;  assign sdata_o[2] = bus5.sdata;
    assign busy_o[2] = bus5.busy;  assign done_o[2]   = bus5.done;    assign ovr_o[2]   = bus5.ovr;

    int checks = 0;
    int errors = 0;

    // monitor state, written only by the monitor process
    int          hi_run [3]    = '{default: 0};
    int          lo_run [3]    = '{default: 0};
    int          busy_run [3]  = '{default: 0};
    int          sync_run [3]  = '{default: 0};
    int          last_busy [3] = '{default: 0};
    int          last_sync [3] = '{default: 0};
    int          done_cnt [3]  = '{default: 0};
    int          falls [3]     = '{default: 0};
    logic [15:0] cap [3]       = '{default: 16'h0};
    bit          hi_ok [3]     = '{default: 1'b0};
    bit          duty_bad [3]  = '{default: 1'b0};
    bit          prev_s [3]    = '{default: 1'b1};

    function automatic int half_of(input int j);
        return (j == 0) ? 2 : (j == 1) ? 1 : 5;
    endfunction

    always @(negedge clk) begin
        for (int j = 0; j < 3; j++) begin
            if (rst) begin
                hi_run[j] = 0; lo_run[j] = 0; busy_run[j] = 0; sync_run[j] = 0;
                hi_ok[j] = 1'b0; prev_s[j] = 1'b1;
            end else begin
                if (sclk_o[j]) begin
                    if (!prev_s[j]) begin
                        if (lo_run[j] != half_of(j)) duty_bad[j] = 1'b1;
                        lo_run[j] = 0;
                        hi_run[j] = 0;
                        hi_ok[j]  = !sync_n_o[j];
                    end
                    hi_run[j] = hi_run[j] + 1;
                end else begin
                    if (prev_s[j]) begin
                        if (hi_ok[j] && hi_run[j] != half_of(j)) duty_bad[j] = 1'b1;
                        hi_run[j] = 0;
                        cap[j]    = {cap[j][14:0], sdata_o[j]};
                        falls[j]  = falls[j] + 1;
                    end
                    lo_run[j] = lo_run[j] + 1;
                end
                prev_s[j] = sclk_o[j];
                if (busy_o[j]) busy_run[j] = busy_run[j] + 1;
                else if (busy_run[j] != 0) begin last_busy[j] = busy_run[j]; busy_run[j] = 0; end
                if (!sync_n_o[j]) sync_run[j] = sync_run[j] + 1;
                else if (sync_run[j] != 0) begin last_sync[j] = sync_run[j]; sync_run[j] = 0; end
                if (done_o[j]) done_cnt[j] = done_cnt[j] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // drive a strobe; returns at E0 + 1 time unit
    task automatic start(input int j, input logic [24:0] v);
        @(negedge clk);
        tx_d[j] = 1'b1;
        y_d[j]  = v;
        @(posedge clk);
        #1;
        tx_d[j] = 1'b0;
        y_d[j]  = 25'h1AAAAAA;
    endtask

    task automatic wait_done(input int j, inout int cyc);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_o[j]) break;
        end
    endtask

    // frame statistics, read inside the done cycle after the monitor has sampled it
    task automatic post_checks(input int j, input logic [15:0] expf, input int f0, input int d0);
        @(negedge clk);
        #1;
        chk("frame", 32'(cap[j]), 32'(expf));
        chk("bit_count", 32'(falls[j] - f0), 32'd16);
        chk("busy_len", 32'(last_busy[j]), 32'(1 + 33 * half_of(j)));
        chk("sync_len", 32'(last_sync[j]), 32'(32 * half_of(j)));
        chk("done_pulse", 32'(done_cnt[j] - d0), 32'd1);
    endtask

    task automatic frame(input int j, input logic [24:0] v, input logic [15:0] expf);
        int cyc;
        int f0;
        int d0;
        cyc = 0;
        f0  = falls[j];
        d0  = done_cnt[j];
        start(j, v);
        chk("busy_at_e0", 32'(busy_o[j]), 32'd1);
        wait_done(j, cyc);
        chk("done_cycle", 32'(cyc), 32'(1 + 33 * half_of(j)));
        post_checks(j, expf, f0, d0);
    endtask

    initial begin
        int cyc;
        int f0;
        int d0;
        for (int j = 0; j < 3; j++) begin tx_d[j] = 1'b0; y_d[j] = '0; end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk",   32'(sclk_o[0]),   32'd1);
        chk("rst_sync_n", 32'(sync_n_o[0]), 32'd1);
        chk("rst_sdata",  32'(sdata_o[0]),  32'd0);
        chk("rst_busy",   32'(busy_o[0]),   32'd0);
        chk("rst_done",   32'(done_o[0]),   32'd0);
        chk("rst_ovr",    32'(ovr_o[0]),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // zero sample, with first-bit timing at E1
        cyc = 0;
        f0  = falls[0];
        d0  = done_cnt[0];
        start(0, 25'h0000000);
        @(posedge clk);
        #1;
        cyc = 1;
        chk("e1_sync_n", 32'(sync_n_o[0]), 32'd0);
        chk("e1_sdata",  32'(sdata_o[0]),  32'd0);
        chk("e1_sclk",   32'(sclk_o[0]),   32'd1);
        wait_done(0, cyc);
        chk("done_cycle_zero", 32'(cyc), 32'd67);
        post_checks(0, 16'h0800, f0, d0);
        chk("ovr_clean", 32'(ovr_o[0]), 32'd0);

        frame(0, 25'h0008000, 16'h0FFF);
        frame(0, 25'h1FF8000, 16'h0000);
        frame(0, 25'h0000010, 16'h0801);
        frame(0, 25'h0FFFFFF, 16'h0FFF);
        frame(0, 25'h1000000, 16'h0000);

        // overrun at cycle 20, then a strobe in the done cycle
        cyc = 0;
        f0  = falls[0];
        d0  = done_cnt[0];
        start(0, 25'h0000010);
        repeat (19) @(posedge clk);
        @(negedge clk);
        tx_d[0] = 1'b1;
        y_d[0]  = 25'h0FFFFFF;
        @(posedge clk);
        #1;
        tx_d[0] = 1'b0;
        cyc = 20;
        chk("ovr_set", 32'(ovr_o[0]), 32'd1);
        wait_done(0, cyc);
        chk("done_cycle_ovr", 32'(cyc), 32'd67);
        @(negedge clk);
        #1;
        chk("frame_ovr", 32'(cap[0]), 32'h0801);
        chk("bit_count_ovr", 32'(falls[0] - f0), 32'd16);
        chk("done_pulse_ovr", 32'(done_cnt[0] - d0), 32'd1);
        f0 = falls[0];
        d0 = done_cnt[0];
        tx_d[0] = 1'b1;
        y_d[0]  = 25'h1000000;
        @(posedge clk);
        #1;
        tx_d[0] = 1'b0;
        chk("done_cycle_accept", 32'(busy_o[0]), 32'd1);
        cyc = 0;
        wait_done(0, cyc);
        chk("done_cycle_b2b", 32'(cyc), 32'd67);
        post_checks(0, 16'h0000, f0, d0);
        chk("ovr_sticky", 32'(ovr_o[0]), 32'd1);

        // asynchronous reset at cycle 30 of a frame
        start(0, 25'h0FFFFFF);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_sclk",   32'(sclk_o[0]),   32'd1);
        chk("arst_sync_n", 32'(sync_n_o[0]), 32'd1);
        chk("arst_sdata",  32'(sdata_o[0]),  32'd0);
        chk("arst_busy",   32'(busy_o[0]),   32'd0);
        chk("arst_ovr",    32'(ovr_o[0]),    32'd0);
        d0 = done_cnt[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("arst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        chk("arst_idle", 32'(busy_o[0]), 32'd0);
        frame(0, 25'h0000010, 16'h0801);

        frame(1, 25'h0000010, 16'h0801);
        frame(2, 25'h0000010, 16'h0801);
        frame(2, 25'h1FF8000, 16'h0000);

        chk("duty_h2", 32'(duty_bad[0]), 32'd0);
        chk("duty_h1", 32'(duty_bad[1]), 32'd0);
        chk("duty_h5", 32'(duty_bad[2]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
